// File: rtl/fifo_stream_reader_pkg.sv
// fifo_rd_pkg: shared types and sizing helpers for the FIFO stream reader
package fifo_rd_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic {RUN, FLUSH} rd_state_t;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read handshake, downstream stream and flush/status signals
interface fifo_stream_reader_if import fifo_rd_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
);

    logic              o_rden;
    logic              i_empty;
    logic              i_alm_empty;
    logic [DATA_W-1:0] i_rddata;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic              i_flush;
    logic              o_flush_busy;
    logic              o_src_low;
    logic [31:0]       o_beat_cnt;

    modport master (
        output o_rden, o_valid, o_data, o_flush_busy, o_src_low, o_beat_cnt,
        input  i_empty, i_alm_empty, i_rddata, i_ready, i_flush
    );

    modport slave (
        input  o_rden, o_valid, o_data, o_flush_busy, o_src_low, o_beat_cnt,
        output i_empty, i_alm_empty, i_rddata, i_ready, i_flush
    );

endinterface

// File: rtl/fifo_stream_reader_rd_out_buf.sv
// rd_out_buf: circular register buffer holding captured FIFO words until accepted downstream
module rd_out_buf import fifo_rd_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_W-1:0]         din,
    output logic [occ_w(DEPTH)-1:0]   occ,
    output logic                      valid,
    output logic [DATA_W-1:0]         dout
);

    localparam int CW = occ_w(DEPTH);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign valid = occ != '0;
    assign dout  = mem[rp];

    // Pointers and occupancy; a pop frees the head slot in the same edge a push may reuse it
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= nxt(wp);
            end
            if (pop) rp <= nxt(rp);
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // The issue logic must never let a word arrive into a full buffer that is not draining
    assert property (@(posedge clk) disable iff (reset || clear) !(push && !pop && occ == CW'(DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a fixed-latency FIFO and re-presents its words as a valid/ready stream
module fifo_stream_reader import fifo_rd_pkg::*; #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2
) (
    input logic                  clk,
    input logic                  reset,
    fifo_stream_reader_if.master bus
);

    localparam int CW = occ_w(BUF_DEPTH);
    localparam int TW = $clog2(RD_LAT_MAX + 1);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
        $error("RD_LAT out of range");
    end
    if (BUF_DEPTH < RD_LAT + 1) begin : g_depth_chk
        $error("BUF_DEPTH must be at least RD_LAT+1");
    end

    rd_state_t         state;
    logic [RD_LAT-1:0] trk;
    logic [RD_LAT-1:0] trk_nxt;
    logic [CW-1:0]     occ;
    logic [TW-1:0]     inflight;
    logic              arrive;
    logic              pop;
    logic              push;
    logic              clear;

    assign arrive   = trk[RD_LAT-1];
    assign pop      = bus.o_valid && bus.i_ready;
    assign inflight = TW'($countones(trk));
    assign clear    = state == RUN && bus.i_flush;
    assign push     = arrive && state == RUN && !bus.i_flush;
    assign trk_nxt  = (trk << 1) | RD_LAT'(bus.o_rden);

    // Issue a read only when the buffer has room for it and everything already in flight
    assign bus.o_rden = !reset && state == RUN && !bus.i_flush && !bus.i_empty &&
                        (int'(occ) + int'(inflight) - int'(pop) < BUF_DEPTH);

    // Flush FSM, in-flight tracker, beat counter and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= RUN;
            trk              <= '0;
            bus.o_beat_cnt   <= '0;
            bus.o_src_low    <= 1'b0;
            bus.o_flush_busy <= 1'b0;
        end else begin
            trk              <= trk_nxt;
            bus.o_src_low    <= bus.i_alm_empty;
            bus.o_beat_cnt   <= pop ? bus.o_beat_cnt + 32'd1 : bus.o_beat_cnt;
            state            <= state == RUN ? (bus.i_flush ? FLUSH : RUN) : (trk_nxt == '0 ? RUN : FLUSH);
            bus.o_flush_busy <= state == RUN ? bus.i_flush : trk_nxt != '0;
        end
    end

    // Reading an empty FIFO would return garbage the stream cannot distinguish
    assert property (@(posedge clk) disable iff (reset) !(bus.o_rden && bus.i_empty));

    rd_out_buf #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (bus.i_rddata),
        .occ   (occ),
        .valid (bus.o_valid),
        .dout  (bus.o_data)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of the stream reader at RD_LAT=1/BUF_DEPTH=2 and RD_LAT=3/BUF_DEPTH=4
module tb_fifo_stream_reader;

    localparam logic [127:0] JUNK = 128'hBAD0_BAD0_BAD0;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_W(128)) b0 ();
    fifo_stream_reader_if #(.DATA_W(128)) b1 ();

    fifo_stream_reader #(.DATA_W(128), .RD_LAT(1), .BUF_DEPTH(2)) u0 (.clk(clk), .reset(rst0), .bus(b0));
    fifo_stream_reader #(.DATA_W(128), .RD_LAT(3), .BUF_DEPTH(4)) u1 (.clk(clk), .reset(rst1), .bus(b1));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] got0[$];
    logic [127:0] got1[$];
    logic [127:0] p0[1];
    logic [127:0] p1[3];
    int rd_n[2];
    int rd_a[2];
    int rd_z[2];
    int v_n[2];
    int v_a[2];
    int v_z[2];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic note(input int d, input logic r, input logic v);
        if (r) begin
            if (rd_n[d] == 0) rd_a[d] = cyc;
            rd_z[d] = cyc;
            rd_n[d]++;
        end
        if (v) begin
            if (v_n[d] == 0) v_a[d] = cyc;
            v_z[d] = cyc;
            v_n[d]++;
        end
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            rd_n[d] = 0; rd_a[d] = 0; rd_z[d] = 0;
            v_n[d] = 0;  v_a[d] = 0;  v_z[d] = 0;
        end
        got0.delete();
        got1.delete();
    endtask

    // One clock: sample handshakes before the edge, then advance the FIFO models after it
    task automatic step();
        logic r0, r1;
        #1;
        r0 = b0.o_rden;
        r1 = b1.o_rden;
        if (b0.o_valid && b0.i_ready) got0.push_back(b0.o_data);
        if (b1.o_valid && b1.i_ready) got1.push_back(b1.o_data);
        note(0, r0, b0.o_valid);
        note(1, r1, b1.o_valid);
        @(posedge clk);
        #1;
        p0[0] = (r0 && q0.size() != 0) ? q0.pop_front() : JUNK;
        b0.i_rddata = p0[0];
        b0.i_empty = q0.size() == 0;
        p1[2] = p1[1];
        p1[1] = p1[0];
        p1[0] = (r1 && q1.size() != 0) ? q1.pop_front() : JUNK;
        b1.i_rddata = p1[2];
        b1.i_empty = q1.size() == 0;
        cyc++;
        #1;
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.i_empty = 1'b0; b0.i_alm_empty = 1'b0; b0.i_rddata = '0; b0.i_ready = 1'b1; b0.i_flush = 1'b0;
        b1.i_empty = 1'b1; b1.i_alm_empty = 1'b0; b1.i_rddata = '0; b1.i_ready = 1'b1; b1.i_flush = 1'b0;
        p0[0] = JUNK;
        for (int i = 0; i < 3; i++) p1[i] = JUNK;
        clr_stats();

        for (int i = 0; i < 3; i++) begin
            b0.i_empty = 1'b0;
            #1 check("rst_rden", b0.o_rden, 0);
            step();
        end
        rst0 = 1'b0;
        #1;
        check("rst_valid", b0.o_valid, 0);
        check("rst_data", b0.o_data, 0);
        check("rst_beat", b0.o_beat_cnt, 0);
        check("rst_src_low", b0.o_src_low, 0);
        check("rst_busy", b0.o_flush_busy, 0);
        step();
        check("idle_valid", b0.o_valid, 0);
        check("idle_beat", b0.o_beat_cnt, 0);

        b0.i_alm_empty = 1'b1;
        step();
        check("src_low_hi", b0.o_src_low, 1);
        b0.i_alm_empty = 1'b0;
        step();
        check("src_low_lo", b0.o_src_low, 0);

        clr_stats();
        q0.push_back(128'hA5A5_0001);
        b0.i_empty = 1'b0;
        #1 check("one_rden", b0.o_rden, 1);
        step();
        check("one_rden_off", b0.o_rden, 0);
        check("one_inflight_valid", b0.o_valid, 0);
        step();
        check("one_valid", b0.o_valid, 1);
        check("one_data", b0.o_data, 128'hA5A5_0001);
        step();
        check("one_valid_off", b0.o_valid, 0);
        check("one_beat", b0.o_beat_cnt, 1);
        check("one_reads", rd_n[0], 1);

        clr_stats();
        for (int i = 0; i < 16; i++) q0.push_back(128'(i));
        b0.i_empty = 1'b0;
        for (int i = 0; i < 40 && got0.size() < 16; i++) step();
        for (int i = 0; i < 4; i++) step();
        check("stream_count", got0.size(), 16);
        for (int i = 0; i < got0.size(); i++) check("stream_data", got0[i], 128'(i));
        check("stream_reads", rd_n[0], 16);
        check("stream_rd_span", rd_z[0] - rd_a[0], 15);
        check("stream_valids", v_n[0], 16);
        check("stream_v_span", v_z[0] - v_a[0], 15);
        check("stream_beat", b0.o_beat_cnt, 17);

        clr_stats();
        for (int i = 16; i < 28; i++) q0.push_back(128'(i));
        b0.i_empty = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp_pre_count", got0.size(), 2);
        b0.i_ready = 1'b0;
        #1 check("bp_rden_stop", b0.o_rden, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_rden", b0.o_rden, 0);
            check("bp_valid", b0.o_valid, 1);
            check("bp_data", b0.o_data, 128'd18);
        end
        check("bp_reads_held", rd_n[0], 4);
        b0.i_ready = 1'b1;
        for (int i = 0; i < 40 && got0.size() < 12; i++) step();
        for (int i = 0; i < 3; i++) step();
        check("bp_count", got0.size(), 12);
        for (int i = 0; i < got0.size(); i++) check("bp_data_order", got0[i], 128'(16 + i));
        check("bp_reads", rd_n[0], 12);
        check("bp_valids", v_n[0], 18);
        check("bp_v_span", v_z[0] - v_a[0], 17);
        check("bp_beat", b0.o_beat_cnt, 29);

        clr_stats();
        b0.i_ready = 1'b0;
        q0.push_back(128'hC0DE);
        q0.push_back(128'hDEAD);
        q0.push_back(128'hBEEF);
        b0.i_empty = 1'b0;
        step();
        step();
        check("fl_pre_valid", b0.o_valid, 1);
        check("fl_pre_data", b0.o_data, 128'hC0DE);
        check("fl_pre_rden", b0.o_rden, 0);
        b0.i_flush = 1'b1;
        step();
        b0.i_flush = 1'b0;
        b0.i_ready = 1'b1;
        #1;
        check("fl_valid", b0.o_valid, 0);
        check("fl_busy", b0.o_flush_busy, 1);
        check("fl_rden", b0.o_rden, 0);
        step();
        check("fl_busy_off", b0.o_flush_busy, 0);
        for (int i = 0; i < 10 && got0.size() < 1; i++) step();
        for (int i = 0; i < 3; i++) step();
        check("fl_count", got0.size(), 1);
        for (int i = 0; i < got0.size(); i++) check("fl_data", got0[i], 128'hBEEF);
        check("fl_reads", rd_n[0], 3);
        check("fl_beat", b0.o_beat_cnt, 30);

        rst1 = 1'b0;
        clr_stats();
        for (int i = 0; i < 20; i++) q1.push_back(128'(i));
        b1.i_empty = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("l3_pre_reads", rd_n[1], 8);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        q1.delete();
        b1.i_empty = 1'b1;
        clr_stats();
        #1;
        check("l3_rst_valid", b1.o_valid, 0);
        check("l3_rst_beat", b1.o_beat_cnt, 0);
        for (int i = 0; i < 16; i++) q1.push_back(128'(100 + i));
        b1.i_empty = 1'b0;
        for (int i = 0; i < 60 && got1.size() < 16; i++) step();
        for (int i = 0; i < 6; i++) step();
        check("l3_count", got1.size(), 16);
        for (int i = 0; i < got1.size(); i++) check("l3_data", got1[i], 128'(100 + i));
        check("l3_reads", rd_n[1], 16);
        check("l3_rd_span", rd_z[1] - rd_a[1], 15);
        check("l3_valids", v_n[1], 16);
        check("l3_v_span", v_z[1] - v_a[1], 15);
        check("l3_beat", b1.o_beat_cnt, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side consumer for the team's 128-bit synchronous FIFO (i_wren/i_rden/i_wrdata, o_full/o_empty/o_alm_full/o_alm_empty/o_rddata). It pops the FIFO through its rden/empty handshake, absorbs the fixed FIFO read latency, and presents the words downstream as a valid/ready stream with full throughput and no data loss under backpressure. It also provides a flush operation that discards buffered and in-flight words.

Parameters:
DATA_W, 128, FIFO word width.
RD_LAT, 1, cycles from an o_rden sampling edge to the edge at which i_rddata is valid and captured; legal range 1..4.
BUF_DEPTH, 2, output buffer entries; must be >= RD_LAT+1 for 1 word/cycle (elaboration assertion).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
o_rden  out  1  FIFO read enable (combinational)
i_empty  in  1  FIFO o_empty
i_alm_empty  in  1  FIFO o_alm_empty (status only; passed to o_src_low)
i_rddata  in  DATA_W  FIFO o_rddata
o_valid  out  1  downstream word valid
i_ready  in  1  downstream accept
o_data  out  DATA_W  downstream word
i_flush  in  1  one-cycle flush request
o_flush_busy  out  1  high while in FLUSH state
o_src_low  out  1  registered copy of i_alm_empty
o_beat_cnt  out  32  accepted-word counter

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset; all state updates on posedge clk.
- Reset values: o_valid=0, o_data=0, o_beat_cnt=0, o_src_low=0, o_flush_busy=0, buffer and in-flight tracker cleared, state=RUN. o_rden=0 combinationally while reset=1.
- In-flight tracker: RD_LAT-bit shift register; it shifts in o_rden each edge. The bit shifting out marks that i_rddata is valid at this edge and is written to the buffer (RUN) or dropped (FLUSH).
- pop = o_valid && i_ready. occ = buffer occupancy; inflight = popcount(tracker).
- o_rden = state==RUN && !i_flush && !i_empty && (occ + inflight - pop) < BUF_DEPTH. The reader never reads an empty FIFO; an overflowed buffer is an assertion failure.
- Latency (RD_LAT=1): o_rden high in cycle 0, data captured at edge 1, o_valid=1 in cycle 1. In general, o_valid rises RD_LAT cycles after the o_rden cycle.
- Ordering: strict FIFO order. o_data and o_valid hold stable while o_valid && !i_ready.
- o_data comes from the buffer head register; o_valid = occ!=0 (registered).
- Simultaneous capture and pop with occ==BUF_DEPTH is legal; occ stays the same.
- o_beat_cnt increments on each pop and wraps 2^32-1 -> 0.
- States:
  - RUN: normal operation. On i_flush, go to FLUSH next edge. A pop in the same cycle still counts in o_beat_cnt. The buffer clears at that edge, so o_valid=0 the next cycle.
  - FLUSH: o_rden=0; tracker arrivals are discarded. When the tracker is all zero after the shift, return to RUN. o_flush_busy=1 in FLUSH. This gives a minimum 1-cycle FLUSH and a maximum RD_LAT cycles. i_flush is ignored in FLUSH.
- Reset mid-operation clears everything at that edge, including in-flight reads; their later FIFO data is ignored.

Decomposition:
- Package fifo_rd_pkg: DATA_W_DEF=128, RD_LAT_MAX=4, rd_state_t enum {RUN, FLUSH}, and a function computing the counter width $clog2(BUF_DEPTH+1).
- Sub-module rd_out_buf: BUF_DEPTH-entry circular register buffer with push/pop/clear, occupancy output and head data. The top level holds the tracker, FSM, o_rden logic and counter.

Test Plan:
- Reset: hold reset 3 cycles with i_empty=0 and i_ready=1 -> o_rden=0 throughout; o_valid=0, o_data=0, o_beat_cnt=0 after release until the first read.
- Single word: i_empty 1->0 for one pop, i_rddata=128'hA5A5_0001 -> o_rden high 1 cycle; o_valid=1 next cycle with o_data=128'hA5A5_0001; with i_ready=1, o_beat_cnt=1 and o_valid=0 after.
- Stream: 16 words 0..15 queued, i_ready=1 -> o_rden high 16 consecutive cycles; o_valid high 16 consecutive cycles; data 0..15 in order; o_beat_cnt=16.
- Backpressure: stream active, i_ready=0 for 6 cycles -> exactly BUF_DEPTH=2 reads outstanding, then o_rden=0; o_data frozen; on i_ready=1, no gap, no loss, no duplicate.
- Flush: i_flush while occ=1 and one read in flight (value 128'hDEAD) -> o_valid=0 next cycle; o_flush_busy=1 one cycle; 128'hDEAD never appears; the next queued word 128'hBEEF is delivered.
- RD_LAT=3, BUF_DEPTH=4 rebuild plus mid-stream reset: full-rate stream resumes after reset; no pre-reset words appear; o_beat_cnt restarts from 0.
